async_fifo_wr_arbiter: RTL and testbench
========================================

// Module: async_fifo_wr_arbiter
// PURPOSE
// - Round-robin write-port arbiter for the async FIFO: shares one wclk-domain write port among NUM_REQ producers.
// - Each producer uses a valid/ready handshake. The arbiter drives winc/wdata into the FIFO and honours wfull.
// - Grants are burst-locked for up to MAX_BURST beats to limit per-beat switching; lives entirely in the wclk domain.
// PARAMETERS
// - NUM_REQ          4    number of producers (2..8)
// - FIFO_DATA_WIDTH  8    data width; must match the FIFO
// - MAX_BURST        4    max beats per grant before forced release (>=1)
// - CNT_W            16   width of the stall counter (optional feature only)
// PORTS
// - wclk        in   1                          write-domain clock
// - wrst_n      in   1                          async active-low reset
// - req_valid   in   NUM_REQ                    producer i has a beat
// - req_data    in   NUM_REQ*FIFO_DATA_WIDTH    producer i data in slice i
// - req_ready   out  NUM_REQ                    beat of producer i accepted this cycle
// - winc        out  1                          FIFO write enable
// - wdata       out  FIFO_DATA_WIDTH            FIFO write data
// - wfull       in   1                          FIFO full flag
// - grant_id    out  $clog2(NUM_REQ)            current/last granted producer
// - busy        out  1                          state==GRANT
// - stall_cnt   out  CNT_W                      only with ASYNC_FIFO_ARB_STATS_EN
// BEHAVIOUR
// - Reset (async, wrst_n low) values:
//   - state=IDLE, grant_id=0, rr_ptr=0, beat_cnt=0.
//   - req_ready=0, winc=0, wdata=0, busy=0, stall_cnt=0.
// - FSM states IDLE, GRANT; grant_id, rr_ptr and beat_cnt are registered.
// - Arbitration: pick the first i with req_valid[i], scanning from rr_ptr upward modulo NUM_REQ.
// - IDLE:
//   - If any req_valid: arbitrate, load grant_id, beat_cnt=0, go GRANT.
//   - This costs exactly 1 cycle of latency from valid to the first possible transfer.
// - GRANT outputs, combinational from registered state:
//   - req_ready[g] = !wfull; all other req_ready bits = 0.
//   - winc = req_valid[g] & !wfull.
//   - wdata = req_data slice g when winc, else all-zero.
// - Transfer: req_valid[g] & req_ready[g] at posedge wclk. Each transfer increments beat_cnt.
// - Release at posedge wclk when either holds:
//   - (a) transfer with beat_cnt==MAX_BURST-1;
//   - (b) req_valid[g]==0 (producer idle).
// - On release:
//   - rr_ptr = (g+1) mod NUM_REQ.
//   - If any req_valid: arbitrate immediately from the new rr_ptr with no bubble, and beat_cnt=0.
//   - Otherwise go IDLE.
// - wfull while in GRANT:
//   - Grant is held and beat_cnt is frozen; no release due to full.
//   - Valid dropping while full still releases per rule (b).
// - Only releasing producer valid: it is re-granted on the next burst (rr wraps to itself).
// - MAX_BURST=1: releases after every transfer, giving pure per-beat round-robin.
// - Producers must hold data stable while valid & !ready. The arbiter never drops or duplicates a beat.
// - Reset mid-burst: outputs clear immediately (async); the partially sent burst is not resumed.
// - grant_id holds its last value in IDLE.
// CONFIGURATION
// - ASYNC_FIFO_ARB_STATS_EN defined:
//   - stall_cnt increments each cycle with busy & req_valid[g] & wfull.
//   - It saturates at all-ones and clears only on reset.
// - Macro undefined: stall_cnt port and logic are absent; all other behaviour is identical.
// TESTING
// - Reset: wrst_n=0 for 6 wclk -> winc=0, wdata=0, req_ready=0, busy=0, grant_id=0.
// - Single producer, MAX_BURST=4:
//   - req_valid=4'b0001 with 8 beats 0x10..0x17.
//   - Expect one idle cycle before beat 1, then 8 consecutive winc.
//   - wdata order 0x10..0x17, no gaps at the burst boundary.
// - Contention, MAX_BURST=4, req_valid=4'b1111 continuous:
//   - Grant sequence 0,1,2,3,0, 4 beats each.
//   - No bubble between bursts; req_ready is one-hot.
// - wfull asserted for 5 cycles mid-burst of producer 2:
//   - winc=0 and req_ready=0 for those cycles; grant_id stays 2.
//   - Burst resumes at the same beat_cnt; no data is lost.
//   - stall_cnt=5 when ASYNC_FIFO_ARB_STATS_EN is defined.
// - Early release: producer 1 drops valid after 2 beats while 3 is valid.
//   - Next grant_id=3, with 3's first beat on the following cycle.
// - Reset mid-burst: assert wrst_n low during beat 2 of producer 0.
//   - winc=0 immediately; after release the arbiter is in IDLE with rr_ptr=0.

Source files
------------

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one async-FIFO write port among NUM_REQ producers (wclk domain).
// Optional stall counter enabled by defining ASYNC_FIFO_ARB_STATS_EN.
module async_fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned FIFO_DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST       = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                                 wclk,
  input  logic                                 wrst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*FIFO_DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic                                 winc,
  output logic [FIFO_DATA_WIDTH-1:0]           wdata,
  input  logic                                 wfull,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id,
  output logic                                 busy
`ifdef ASYNC_FIFO_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]                     stall_cnt
`endif
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned DW = FIFO_DATA_WIDTH;
  localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     grant_id_q, grant_id_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;

  logic                 g_valid;
  logic [DW-1:0]        g_data;
  logic [GW-1:0]        g_next;
  logic [GW-1:0]        arb_ptr;
  logic [GW-1:0]        arb_id;
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0]   rot_valid;
  int unsigned          arb_sum;
  logic                 any_valid;
  logic                 xfer;
  logic                 release_g;

  // Currently granted producer's request and data.
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == GW'(i)) begin
        g_valid = req_valid[i];
        g_data  = req_data[i*DW +: DW];
      end
    end
  end

  assign g_next    = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + GW'(1);
  assign any_valid = |req_valid;
  // On release the scan starts past the current grant; from IDLE it starts at rr_ptr.
  assign arb_ptr   = (state_q == GRANT) ? g_next : rr_ptr_q;

  // Rotate so that arb_ptr lands at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    dbl_valid = {req_valid, req_valid};
    rot_valid = NUM_REQ'(dbl_valid >> arb_ptr);
    arb_sum   = 32'(arb_ptr);
    for (int unsigned j = NUM_REQ; j > 0; j--) begin
      if (rot_valid[j-1]) arb_sum = 32'(arb_ptr) + (j - 1);
    end
    arb_id = (arb_sum >= NUM_REQ) ? GW'(arb_sum - NUM_REQ) : GW'(arb_sum);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    req_ready  = '0;
    winc       = 1'b0;
    wdata      = '0;
    xfer       = 1'b0;
    release_g  = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_id_d = arb_id;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (grant_id_q == GW'(i)) req_ready[i] = ~wfull;
        end
        xfer      = g_valid & ~wfull;
        winc      = xfer;
        wdata     = xfer ? g_data : '0;
        release_g = (xfer && (beat_cnt_q == LAST_BEAT)) || !g_valid;
        if (xfer) beat_cnt_d = beat_cnt_q + BW'(1);
        if (release_g) begin
          rr_ptr_d   = g_next;
          beat_cnt_d = '0;
          if (any_valid) begin
            grant_id_d = arb_id;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q == GRANT);

`ifdef ASYNC_FIFO_ARB_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles the granted producer is blocked by a full FIFO.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == GRANT) && g_valid && wfull && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed bench for async_fifo_wr_arbiter: burst, contention, full-stall, early release and reset cases.
module tb_async_fifo_wr_arbiter;

  logic        wclk;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        winc;
  logic [7:0]  wdata;
  logic        wfull;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef ASYNC_FIFO_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int n_vec;
  int n_err;

  logic [7:0] nxt  [4];
  int         left [4];

  async_fifo_wr_arbiter dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .winc      (winc),
    .wdata     (wdata),
    .wfull     (wfull),
    .grant_id  (grant_id),
    .busy      (busy)
`ifdef ASYNC_FIFO_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive producer inputs from the producer model.
  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]        = (left[i] > 0);
      req_data[i*8 +: 8]  = nxt[i];
    end
  endtask

  // One clock: beats accepted at this edge advance their producer, then inputs settle.
  task automatic tick();
    logic [3:0] acc;
    acc = req_valid & req_ready;
    @(posedge wclk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        nxt[i]  = nxt[i] + 8'd1;
        left[i] = left[i] - 1;
      end
    end
    apply();
    #1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    wfull  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      left[i] = 0;
      nxt[i]  = 8'h00;
    end
    apply();
    repeat (6) tick();
  endtask

  task automatic end_reset();
    wrst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [1:0] gseq [5];
    logic [7:0] gbase [5];
    n_vec     = 0;
    n_err     = 0;
    req_valid = '0;
    req_data  = '0;
    wfull     = 1'b0;
    wrst_n    = 1'b0;

    // Reset state
    do_reset();
    chk("rst_winc", 32'(winc), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    end_reset();

    // Single producer, 8 beats across two bursts with no gap
    left[0] = 8;
    nxt[0]  = 8'h10;
    apply();
    #1;
    chk("single_idle_winc", 32'(winc), 32'd0);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("single_winc", 32'(winc), 32'd1);
      chk("single_wdata", 32'(wdata), 32'h10 + 32'(k));
      tick();
    end
    chk("single_done_winc", 32'(winc), 32'd0);
    tick();
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_gid", 32'(grant_id), 32'd0);

    // Contention: all four producers, 4-beat bursts 0,1,2,3,0
    do_reset();
    end_reset();
    left[0] = 8; nxt[0] = 8'h20;
    left[1] = 4; nxt[1] = 8'h30;
    left[2] = 4; nxt[2] = 8'h40;
    left[3] = 4; nxt[3] = 8'h50;
    apply();
    #1;
    gseq[0] = 2'd0; gbase[0] = 8'h20;
    gseq[1] = 2'd1; gbase[1] = 8'h30;
    gseq[2] = 2'd2; gbase[2] = 8'h40;
    gseq[3] = 2'd3; gbase[3] = 8'h50;
    gseq[4] = 2'd0; gbase[4] = 8'h24;
    tick();
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) begin
        chk("cont_gid", 32'(grant_id), 32'(gseq[b]));
        chk("cont_wdata", 32'(wdata), 32'(gbase[b]) + 32'(k));
        chk("cont_ready", 32'(req_ready), 32'd1 << gseq[b]);
        tick();
      end
    end

    // wfull for 5 cycles mid-burst of producer 2; producer 3 waits
    do_reset();
    end_reset();
    left[2] = 6; nxt[2] = 8'h60;
    left[3] = 2; nxt[3] = 8'h80;
    apply();
    #1;
    tick();
    chk("full_pre0", 32'(wdata), 32'h60);
    tick();
    chk("full_pre1", 32'(wdata), 32'h61);
    tick();
    wfull = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("full_winc", 32'(winc), 32'd0);
      chk("full_ready", 32'(req_ready), 32'd0);
      chk("full_gid", 32'(grant_id), 32'd2);
      tick();
    end
    wfull = 1'b0;
    #1;
    chk("full_resume2", 32'(wdata), 32'h62);
    chk("full_resume_winc", 32'(winc), 32'd1);
    tick();
    chk("full_resume3", 32'(wdata), 32'h63);
    tick();
    chk("full_switch_gid", 32'(grant_id), 32'd3);
    chk("full_switch_wdata", 32'(wdata), 32'h80);
`ifdef ASYNC_FIFO_ARB_STATS_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd5);
`endif

    // Early release: producer 1 drops valid after 2 beats, 3 waiting
    do_reset();
    end_reset();
    left[1] = 2; nxt[1] = 8'h90;
    left[3] = 3; nxt[3] = 8'hA0;
    apply();
    #1;
    tick();
    chk("early_gid1", 32'(grant_id), 32'd1);
    chk("early_b0", 32'(wdata), 32'h90);
    tick();
    chk("early_b1", 32'(wdata), 32'h91);
    tick();
    chk("early_drop_winc", 32'(winc), 32'd0);
    chk("early_drop_gid", 32'(grant_id), 32'd1);
    tick();
    chk("early_next_gid", 32'(grant_id), 32'd3);
    chk("early_next_winc", 32'(winc), 32'd1);
    chk("early_next_wdata", 32'(wdata), 32'hA0);

    // Reset asserted during beat 2 of producer 0
    do_reset();
    end_reset();
    left[0] = 4; nxt[0] = 8'hB0;
    left[1] = 1; nxt[1] = 8'hC0;
    apply();
    #1;
    tick();
    chk("mid_b0", 32'(wdata), 32'hB0);
    tick();
    chk("mid_b1_winc", 32'(winc), 32'd1);
    wrst_n = 1'b0;
    #1;
    chk("mid_rst_winc", 32'(winc), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    end_reset();
    chk("mid_idle_busy", 32'(busy), 32'd0);
    chk("mid_idle_gid", 32'(grant_id), 32'd0);
    tick();
    chk("mid_regrant_gid", 32'(grant_id), 32'd0);
    chk("mid_regrant_wdata", 32'(wdata), 32'hB1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
